time_entry_capture: RTL and testbench

//  Downstream of the hour/minute/second enable FSM in the alarm/time-setting path.

---
 rtl/time_entry_capture.sv | 153 +++++++++++++++
 tb/tb_time_entry_capture.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_entry_capture.sv
// Keypad time-entry staging for the alarm/time-setting path. Digits go into the
// hour/minute/second field picked by the enables. A completeSetting rising edge
// range-checks the staged time. It then either commits the time to set_* with a
// one-cycle set_load pulse, or pulses set_error and leaves set_* unchanged.
module time_entry_capture #(
  parameter int unsigned MAX_HOUR   = 23,
  parameter int unsigned MAX_MINSEC = 59,
  parameter logic [3:0]  CLEAR_CODE = 4'hA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       hour_en,
  input  logic       min_en,
  input  logic       sec_en,
  input  logic       completeSetting,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       set_load,
  output logic       set_error,
  output logic [1:0] active_field,
  output logic [6:0] active_value
);

  localparam logic [6:0] MaxHour   = 7'(MAX_HOUR);
  localparam logic [6:0] MaxMinSec = 7'(MAX_MINSEC);

  localparam logic [1:0] FieldNone = 2'd0;
  localparam logic [1:0] FieldHour = 2'd1;
  localparam logic [1:0] FieldMin  = 2'd2;
  localparam logic [1:0] FieldSec  = 2'd3;

  // Staging index: 0 hour, 1 minute, 2 second.
  logic [2:0]      en, en_q, en_rise;
  logic            cs_q, cs_rise;
  logic [2:0][6:0] val_q, val_d;
  logic [2:0][1:0] cnt_q, cnt_d;
  logic [1:0]      field, idx;
  logic            key_ok, in_range;
  logic [4:0]      set_hour_q, set_hour_d;
  logic [5:0]      set_min_q, set_min_d;
  logic [5:0]      set_sec_q, set_sec_d;
  logic            set_load_q, set_load_d;
  logic            set_error_q, set_error_d;

  assign en      = {sec_en, min_en, hour_en};
  assign en_rise = en & ~en_q;
  assign cs_rise = completeSetting & ~cs_q;
  assign idx     = field - 2'd1;
  assign key_ok  = key_valid && (field != FieldNone) && !completeSetting;

  // Field select, seconds take priority over minutes over hours.
  always_comb begin
    if (sec_en)       field = FieldSec;
    else if (min_en)  field = FieldMin;
    else if (hour_en) field = FieldHour;
    else              field = FieldNone;
  end

  // Staging next-state: enable-rise clears first, then the key acts on the active field.
  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (en_rise[i]) begin
        val_d[i] = '0;
        cnt_d[i] = '0;
      end
    end
    if (key_ok) begin
      if (key_code <= 4'd9) begin
        if (cnt_d[idx] == 2'd1) begin
          // First digit is at most 9, so the result never exceeds 99.
          val_d[idx] = val_d[idx] * 7'd10 + {3'b000, key_code};
          cnt_d[idx] = 2'd2;
        end else begin
          val_d[idx] = {3'b000, key_code};
          cnt_d[idx] = 2'd1;
        end
      end else if (key_code == CLEAR_CODE) begin
        val_d[idx] = '0;
        cnt_d[idx] = '0;
      end
    end
  end

  assign in_range = (val_q[0] <= MaxHour) && (val_q[1] <= MaxMinSec) &&
                    (val_q[2] <= MaxMinSec);

  // Commit next-state: outputs follow one cycle after the completeSetting edge.
  always_comb begin
    set_hour_d  = set_hour_q;
    set_min_d   = set_min_q;
    set_sec_d   = set_sec_q;
    set_load_d  = 1'b0;
    set_error_d = 1'b0;
    if (cs_rise) begin
      if (in_range) begin
        set_hour_d = val_q[0][4:0];
        set_min_d  = val_q[1][5:0];
        set_sec_d  = val_q[2][5:0];
        set_load_d = 1'b1;
      end else begin
        set_error_d = 1'b1;
      end
    end
  end

  // Staged value of the selected field for the display.
  always_comb begin
    unique case (field)
      FieldHour: active_value = val_q[0];
      FieldMin:  active_value = val_q[1];
      FieldSec:  active_value = val_q[2];
      default:   active_value = 7'd0;
    endcase
  end

  // State registers; reset discards staging and suppresses any same-cycle commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_q        <= '0;
      cs_q        <= 1'b0;
      val_q       <= '0;
      cnt_q       <= '0;
      set_hour_q  <= '0;
      set_min_q   <= '0;
      set_sec_q   <= '0;
      set_load_q  <= 1'b0;
      set_error_q <= 1'b0;
    end else begin
      en_q        <= en;
      cs_q        <= completeSetting;
      val_q       <= val_d;
      cnt_q       <= cnt_d;
      set_hour_q  <= set_hour_d;
      set_min_q   <= set_min_d;
      set_sec_q   <= set_sec_d;
      set_load_q  <= set_load_d;
      set_error_q <= set_error_d;
    end
  end

  assign set_hour     = set_hour_q;
  assign set_min      = set_min_q;
  assign set_sec      = set_sec_q;
  assign set_load     = set_load_q;
  assign set_error    = set_error_q;
  assign active_field = field;

endmodule

// File: tb/tb_time_entry_capture.sv
// Bench for time_entry_capture: directed scenarios followed by random key/enable
// traffic, every cycle compared against a behavioural model of the entry rules.
module tb_time_entry_capture;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       hour_en, min_en, sec_en;
  logic       completeSetting;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic       set_load, set_error;
  logic [1:0] active_field;
  logic [6:0] active_value;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: per field (0 hour, 1 min, 2 sec) value and digits typed so far.
  int m_val[3];
  int m_cnt[3];
  int m_sh, m_sm, m_ss, m_load, m_err;
  int m_prev_en[3];
  int m_prev_cs;
  int m_field;  // -1 when no field is selected

  time_entry_capture dut (
    .clock          (clock),
    .reset          (reset),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .hour_en        (hour_en),
    .min_en         (min_en),
    .sec_en         (sec_en),
    .completeSetting(completeSetting),
    .set_hour       (set_hour),
    .set_min        (set_min),
    .set_sec        (set_sec),
    .set_load       (set_load),
    .set_error      (set_error),
    .active_field   (active_field),
    .active_value   (active_value)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input int exp);
    n_cmp++;
    assert (obs === 8'(exp))
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int field_of(input int e[3]);
    if (e[2] != 0) return 2;
    if (e[1] != 0) return 1;
    if (e[0] != 0) return 0;
    return -1;
  endfunction

  // One clock edge of the entry rules, applied to the inputs present at that edge.
  task automatic model_edge(input int rst, input int kv, input int kc, input int e[3],
                            input int cs);
    if (rst != 0) begin
      for (int i = 0; i < 3; i++) begin
        m_val[i] = 0; m_cnt[i] = 0; m_prev_en[i] = 0;
      end
      m_sh = 0; m_sm = 0; m_ss = 0; m_load = 0; m_err = 0; m_prev_cs = 0;
      return;
    end
    m_load = 0;
    m_err  = 0;
    if (cs != 0 && m_prev_cs == 0) begin
      if (m_val[0] <= 23 && m_val[1] <= 59 && m_val[2] <= 59) begin
        m_sh = m_val[0]; m_sm = m_val[1]; m_ss = m_val[2]; m_load = 1;
      end else begin
        m_err = 1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (e[i] != 0 && m_prev_en[i] == 0) begin
        m_val[i] = 0; m_cnt[i] = 0;
      end
    end
    begin
      int f;
      f = field_of(e);
      if (kv != 0 && f >= 0 && cs == 0) begin
        if (kc <= 9) begin
          if (m_cnt[f] == 1) begin
            m_val[f] = m_val[f] * 10 + kc; m_cnt[f] = 2;
          end else begin
            m_val[f] = kc; m_cnt[f] = 1;
          end
        end else if (kc == 10) begin
          m_val[f] = 0; m_cnt[f] = 0;
        end
      end
    end
    for (int i = 0; i < 3; i++) m_prev_en[i] = e[i];
    m_prev_cs = cs;
  endtask

  // Advance one clock, update the model, then compare every output 1 time unit later.
  task automatic tick();
    int r, kv, kc, cs;
    int e[3];
    int f;
    r = int'(reset); kv = int'(key_valid); kc = int'(key_code); cs = int'(completeSetting);
    e[0] = int'(hour_en); e[1] = int'(min_en); e[2] = int'(sec_en);
    @(posedge clock);
    model_edge(r, kv, kc, e, cs);
    #1;
    f = field_of(e);
    chk("set_hour", 8'(set_hour), m_sh);
    chk("set_min", 8'(set_min), m_sm);
    chk("set_sec", 8'(set_sec), m_ss);
    chk("set_load", 8'(set_load), m_load);
    chk("set_error", 8'(set_error), m_err);
    chk("active_field", 8'(active_field), f + 1);
    chk("active_value", 8'(active_value), (f < 0) ? 0 : m_val[f]);
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
    tick();
  endtask

  initial begin
    int loads;
    reset = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    hour_en = 1'b0; min_en = 1'b0; sec_en = 1'b0; completeSetting = 1'b0;
    tick();
    tick();
    chk("rst_load", 8'(set_load), 0);
    chk("rst_hour", 8'(set_hour), 0);
    reset = 1'b0;
    tick();

    // Full valid entry 12:34:56.
    hour_en = 1'b1; tick(); press(4'd1); press(4'd2); hour_en = 1'b0;
    min_en = 1'b1;  tick(); press(4'd3); press(4'd4); min_en = 1'b0;
    sec_en = 1'b1;  tick(); press(4'd5); press(4'd6); sec_en = 1'b0;
    completeSetting = 1'b1; tick();
    chk("t1_load", 8'(set_load), 1);
    chk("t1_hour", 8'(set_hour), 12);
    chk("t1_min", 8'(set_min), 34);
    chk("t1_sec", 8'(set_sec), 56);
    tick();
    chk("t1_load_once", 8'(set_load), 0);
    completeSetting = 1'b0; tick();

    // Out-of-range hour 25 rejects the commit.
    hour_en = 1'b1; tick(); press(4'd2); press(4'd5); hour_en = 1'b0;
    min_en = 1'b1;  tick(); press(4'd0); press(4'd0); min_en = 1'b0;
    sec_en = 1'b1;  tick(); press(4'd0); press(4'd0); sec_en = 1'b0;
    completeSetting = 1'b1; tick();
    chk("t2_error", 8'(set_error), 1);
    chk("t2_load", 8'(set_load), 0);
    chk("t2_hour_held", 8'(set_hour), 12);
    tick();
    chk("t2_error_once", 8'(set_error), 0);
    completeSetting = 1'b0; tick();

    // Third digit restarts, clear and ignored codes.
    min_en = 1'b1; tick();
    press(4'd1); press(4'd2); press(4'd7);
    chk("t3_restart", 8'(active_value), 7);
    press(4'hA);
    chk("t3_clear", 8'(active_value), 0);
    press(4'hB);
    chk("t3_ignore", 8'(active_value), 0);
    press(4'd4);

    // Seconds win priority; minutes keep their staged 4.
    sec_en = 1'b1; key_valid = 1'b1; key_code = 4'd9; tick();
    key_valid = 1'b0; tick();
    chk("t4_field", 8'(active_field), 3);
    chk("t4_sec", 8'(active_value), 9);
    sec_en = 1'b0; tick();
    chk("t4_min_kept", 8'(active_value), 4);
    min_en = 1'b0; tick();

    // Reset mid-entry discards staging; later commit loads zeros.
    hour_en = 1'b1; tick(); press(4'd1); press(4'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_rst_hour", 8'(set_hour), 0);
    chk("t5_rst_value", 8'(active_value), 0);
    tick();
    completeSetting = 1'b1; tick();
    chk("t5_load", 8'(set_load), 1);
    chk("t5_hour", 8'(set_hour), 0);
    completeSetting = 1'b0; tick();

    // Held completeSetting: one load, keys ignored.
    press(4'd7);
    completeSetting = 1'b1;
    loads = 0;
    for (int i = 0; i < 10; i++) begin
      key_valid = i[0];
      key_code  = 4'($urandom_range(9));
      tick();
      if (set_load === 1'b1) loads++;
    end
    key_valid = 1'b0;
    chk("t6_one_load", 8'(loads), 1);
    chk("t6_staging", 8'(active_value), 7);
    completeSetting = 1'b0; hour_en = 1'b0; tick();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(63) == 0);
      key_valid = $urandom_range(1) == 1;
      key_code  = 4'($urandom_range(15));
      if ($urandom_range(7) == 0) hour_en = ~hour_en;
      if ($urandom_range(7) == 0) min_en = ~min_en;
      if ($urandom_range(9) == 0) sec_en = ~sec_en;
      if ($urandom_range(11) == 0) completeSetting = ~completeSetting;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
